// File: rtl/alu_sequencer_if.sv
// Bus bundle between the sequencer and its instruction ROM and external 4-bit ALU.
// The sequencer is the master: it drives the fetch address/request and the ALU operands.
interface alu_sequencer_if;
  logic [11:0] rom_addr;
  logic        rom_req;
  logic        rom_ack;
  logic [7:0]  rom_data;
  logic [3:0]  alu_op;
  logic [3:0]  alu_acc;
  logic [3:0]  alu_opa;
  logic        alu_cin;
  logic [3:0]  alu_result;
  logic        alu_cout;
  logic        alu_zero;

  modport master (
    output rom_addr, rom_req, alu_op, alu_acc, alu_opa, alu_cin,
    input  rom_ack, rom_data, alu_result, alu_cout, alu_zero
  );

  modport slave (
    input  rom_addr, rom_req, alu_op, alu_acc, alu_opa, alu_cin,
    output rom_ack, rom_data, alu_result, alu_cout, alu_zero
  );
endinterface

// File: rtl/alu_sequencer.sv
// 4-bit accumulator sequencer: fetches byte instructions from ROM (two bytes for JUN),
// drives an external ALU for one EXEC cycle and writes back acc, carry, zero and R0..R15.
module alu_sequencer (
  input  logic                   clk,
  input  logic                   rst,
  alu_sequencer_if.master        bus,
  input  logic [3:0]             i_reg_rd_addr,
  output logic [3:0]             o_reg_rd_data,
  output logic [3:0]             o_acc_out,
  output logic                   o_cy_out,
  output logic                   o_zero_flag,
  output logic                   o_illegal_op,
  output logic [1:0]             o_state
);

  typedef enum logic [1:0] {FETCH1 = 2'd0, FETCH2 = 2'd1, EXEC = 2'd2} state_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h8;
  localparam logic [3:0] OP_SUB = 4'h9;
  localparam logic [3:0] OP_LDM = 4'hD;

  state_e      r_state, w_next_state;
  logic [11:0] r_pc;
  logic [7:0]  r_ir;
  logic [3:0]  r_acc;
  logic        r_cy;
  logic        r_zero;
  logic [3:0]  r_regs [16];

  logic [3:0]  w_opr, w_n, w_rn;
  logic        w_acc_we, w_cy_we, w_zero_we, w_reg_we, w_illegal;
  logic [3:0]  w_acc_d, w_reg_d;
  logic        w_cy_d;

  assign w_opr = r_ir[7:4];
  assign w_n   = r_ir[3:0];
  assign w_rn  = r_regs[w_n];

  assign bus.rom_addr = r_pc;
  assign bus.rom_req  = !rst && (r_state != EXEC);
  assign o_reg_rd_data = r_regs[i_reg_rd_addr];
  assign o_acc_out     = r_acc;
  assign o_cy_out      = r_cy;
  assign o_zero_flag   = r_zero;
  assign o_illegal_op  = w_illegal && !rst;
  assign o_state       = r_state;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= FETCH1;
    else     r_state <= w_next_state;
  end

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    bus.alu_op   = OP_NOP;
    bus.alu_acc  = r_acc;
    bus.alu_opa  = 4'h0;
    bus.alu_cin  = 1'b0;
    w_acc_we     = 1'b0;
    w_acc_d      = r_acc;
    w_cy_we      = 1'b0;
    w_cy_d       = r_cy;
    w_zero_we    = 1'b0;
    w_reg_we     = 1'b0;
    w_reg_d      = w_rn;
    w_illegal    = 1'b0;

    case (r_state)
      FETCH1: if (bus.rom_ack) w_next_state = (bus.rom_data[7:4] == 4'h4) ? FETCH2 : EXEC;
      FETCH2: if (bus.rom_ack) w_next_state = FETCH1;
      EXEC: begin
        w_next_state = FETCH1;
        case (w_opr)
          4'h6: begin
            bus.alu_op  = OP_ADD;
            bus.alu_acc = w_rn;
            bus.alu_opa = 4'h1;
            w_reg_we    = 1'b1;
            w_reg_d     = bus.alu_result;
          end
          4'h8, 4'h9: begin
            bus.alu_op  = (w_opr == 4'h8) ? OP_ADD : OP_SUB;
            bus.alu_opa = w_rn;
            bus.alu_cin = r_cy;
            w_acc_we    = 1'b1;
            w_acc_d     = bus.alu_result;
            w_cy_we     = 1'b1;
            w_cy_d      = bus.alu_cout;
            w_zero_we   = 1'b1;
          end
          4'hA, 4'hD: begin
            bus.alu_op  = OP_LDM;
            bus.alu_opa = (w_opr == 4'hA) ? w_rn : w_n;
            w_acc_we    = 1'b1;
            w_acc_d     = bus.alu_result;
            w_zero_we   = 1'b1;
          end
          4'hB: begin
            w_acc_we = 1'b1;
            w_acc_d  = w_rn;
            w_reg_we = 1'b1;
            w_reg_d  = r_acc;
          end
          4'hF: begin
            case (w_n)
              4'h0: begin w_acc_we = 1'b1; w_acc_d = 4'h0; w_cy_we = 1'b1; w_cy_d = 1'b0; end
              4'h1: begin w_cy_we = 1'b1; w_cy_d = 1'b0; end
              4'h3: begin w_cy_we = 1'b1; w_cy_d = !r_cy; end
              4'hA: begin w_cy_we = 1'b1; w_cy_d = 1'b1; end
              4'h2: begin
                bus.alu_op  = OP_ADD;
                bus.alu_opa = 4'h1;
                w_acc_we    = 1'b1;
                w_acc_d     = bus.alu_result;
                w_cy_we     = 1'b1;
                w_cy_d      = bus.alu_cout;
                w_zero_we   = 1'b1;
              end
              default: ;
            endcase
          end
          4'h1, 4'h2, 4'h3, 4'h5, 4'h7, 4'hC, 4'hE: w_illegal = 1'b1;
          default: ;
        endcase
      end
      default: w_next_state = FETCH1;
    endcase
  end

  // NOTE: the register file is reset explicitly because R0..R15 must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc   <= 12'h000;
      r_ir   <= 8'h00;
      r_acc  <= 4'h0;
      r_cy   <= 1'b0;
      r_zero <= 1'b0;
      for (int i = 0; i < 16; i++) r_regs[i] <= 4'h0;
    end else begin
      case (r_state)
        FETCH1: if (bus.rom_ack) begin
          r_ir <= bus.rom_data;
          r_pc <= r_pc + 12'd1;
        end
        FETCH2: if (bus.rom_ack) r_pc <= {r_ir[3:0], bus.rom_data};
        EXEC: begin
          if (w_acc_we)  r_acc       <= w_acc_d;
          if (w_cy_we)   r_cy        <= w_cy_d;
          if (w_zero_we) r_zero      <= bus.alu_zero;
          if (w_reg_we)  r_regs[w_n] <= w_reg_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Instruction-level self-checking bench for alu_sequencer: directed scenarios then random
// programs, compared against an architectural model and a behavioural ALU.
module tb_alu_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] reg_rd_addr = 4'h0;
  logic [3:0] reg_rd_data, acc_out;
  logic       cy_out, zero_flag, illegal_op;
  logic [1:0] state;
  logic [4:0] alu_t;

  int passed = 0;
  int total  = 0;

  logic [11:0] m_pc;
  logic [3:0]  m_acc;
  logic        m_cy, m_zf;
  logic [3:0]  m_r [16];

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .i_reg_rd_addr (reg_rd_addr),
    .o_reg_rd_data (reg_rd_data),
    .o_acc_out     (acc_out),
    .o_cy_out      (cy_out),
    .o_zero_flag   (zero_flag),
    .o_illegal_op  (illegal_op),
    .o_state       (state)
  );

  always #5 clk = ~clk;

  // External ALU: SUB reports a raw borrow in alu_cout.
  always_comb begin
    alu_t          = 5'd0;
    bus.alu_result = bus.alu_acc;
    bus.alu_cout   = 1'b0;
    case (bus.alu_op)
      4'h8: begin
        alu_t = {1'b0, bus.alu_acc} + {1'b0, bus.alu_opa} + {4'd0, bus.alu_cin};
        bus.alu_result = alu_t[3:0];
        bus.alu_cout   = alu_t[4];
      end
      4'h9: begin
        alu_t = {1'b0, bus.alu_acc} - {1'b0, bus.alu_opa} - {4'd0, bus.alu_cin};
        bus.alu_result = alu_t[3:0];
        bus.alu_cout   = alu_t[4];
      end
      4'hD: bus.alu_result = bus.alu_opa;
      default: ;
    endcase
    bus.alu_zero = (bus.alu_result == 4'h0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc = 12'h000; m_acc = 4'h0; m_cy = 1'b0; m_zf = 1'b0;
    for (int i = 0; i < 16; i++) m_r[i] = 4'h0;
  endtask

  // Architectural effect of one single-byte instruction, plus the ALU op and
  // illegal flag it must present during its execute cycle.
  task automatic model_exec(input logic [7:0] b, output logic [3:0] eop, output logic eill);
    int s;
    logic [3:0] n, tmp;
    n = b[3:0]; eop = 4'h0; eill = 1'b0;
    case (b[7:4])
      4'h6: begin eop = 4'h8; m_r[n] = m_r[n] + 4'd1; end
      4'h8: begin
        eop = 4'h8; s = int'(m_acc) + int'(m_r[n]) + int'(m_cy);
        m_acc = s[3:0]; m_cy = (s > 15); m_zf = (m_acc == 0);
      end
      4'h9: begin
        eop = 4'h9; s = int'(m_acc) - int'(m_r[n]) - int'(m_cy);
        m_acc = s[3:0]; m_cy = (s < 0); m_zf = (m_acc == 0);
      end
      4'hA: begin eop = 4'hD; m_acc = m_r[n]; m_zf = (m_acc == 0); end
      4'hB: begin tmp = m_acc; m_acc = m_r[n]; m_r[n] = tmp; end
      4'hD: begin eop = 4'hD; m_acc = n; m_zf = (m_acc == 0); end
      4'hF: case (n)
        4'h0: begin m_acc = 4'h0; m_cy = 1'b0; end
        4'h1: m_cy = 1'b0;
        4'h3: m_cy = ~m_cy;
        4'hA: m_cy = 1'b1;
        4'h2: begin
          eop = 4'h8; s = int'(m_acc) + 1;
          m_acc = s[3:0]; m_cy = (s > 15); m_zf = (m_acc == 0);
        end
        default: ;
      endcase
      4'h1, 4'h2, 4'h3, 4'h5, 4'h7, 4'hC, 4'hE: eill = 1'b1;
      default: ;
    endcase
  endtask

  // Hold ack low for 'waits' cycles, then present byte b with ack for one edge.
  task automatic step_ack(input logic [7:0] b, input int waits, input logic [1:0] exp_st);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      bus.rom_ack = 1'b0; bus.rom_data = 8'($urandom);
      check("wait_req", bus.rom_req, 1'b1);
      check("wait_addr", bus.rom_addr, m_pc);
      check("wait_state", state, exp_st);
    end
    @(negedge clk);
    bus.rom_ack = 1'b1; bus.rom_data = b;
    check("fetch_addr", bus.rom_addr, m_pc);
    check("fetch_state", state, exp_st);
    @(posedge clk);
  endtask

  task automatic exec_instr(input logic [7:0] b1, input logic [7:0] b2, input int waits);
    logic [3:0] eop;
    logic eill;
    step_ack(b1, waits, 2'd0);
    m_pc = m_pc + 12'd1;
    if (b1[7:4] == 4'h4) begin
      step_ack(b2, waits, 2'd1);
      m_pc = {b1[3:0], b2};
    end else begin
      @(negedge clk);
      bus.rom_ack = 1'b0;
      model_exec(b1, eop, eill);
      check("exec_state", state, 2'd2);
      check("exec_req", bus.rom_req, 1'b0);
      check("exec_alu_op", bus.alu_op, eop);
      check("exec_illegal", illegal_op, eill);
      @(posedge clk);
    end
  endtask

  task automatic check_arch();
    int k;
    @(negedge clk);
    bus.rom_ack = 1'b0;
    k = $urandom_range(0, 15);
    reg_rd_addr = 4'(k);
    #1;
    check("pc", bus.rom_addr, m_pc);
    check("state_fetch1", state, 2'd0);
    check("acc", acc_out, m_acc);
    check("cy", cy_out, m_cy);
    check("zero", zero_flag, m_zf);
    check("illegal_idle", illegal_op, 1'b0);
    check("reg", reg_rd_data, m_r[k]);
  endtask

  task automatic run(input logic [7:0] b1, input logic [7:0] b2);
    exec_instr(b1, b2, 0);
    check_arch();
  endtask

  initial begin
    logic [7:0] b1, b2;
    bus.rom_ack = 1'b0; bus.rom_data = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_req", bus.rom_req, 1'b0);
    check("rst_pc", bus.rom_addr, 12'h000);
    check("rst_state", state, 2'd0);
    check("rst_acc", acc_out, 4'h0);
    check("rst_illegal", illegal_op, 1'b0);
    for (int i = 0; i < 16; i++) begin
      reg_rd_addr = 4'(i); #1;
      check("rst_reg", reg_rd_data, 4'h0);
    end
    rst = 1'b0;
    #1 check("rel_req", bus.rom_req, 1'b1);

    // LDM 5 with immediate ack
    run(8'hD5, 8'h00);
    check("ldm5_acc", acc_out, 4'h5);
    check("ldm5_pc", bus.rom_addr, 12'h001);

    // acc=9, cy=0, R3=8 then ADD R3
    run(8'hD8, 8'h00); run(8'hB3, 8'h00); run(8'hD9, 8'h00); run(8'hF1, 8'h00);
    run(8'h83, 8'h00);
    check("add_acc", acc_out, 4'h1);
    check("add_cy", cy_out, 1'b1);
    check("add_zero", zero_flag, 1'b0);

    // JUN to 0x010, then JUN 0x2AB from there; waits exercise rom_addr stability
    run(8'h40, 8'h10);
    check("jun_pc10", bus.rom_addr, 12'h010);
    exec_instr(8'h42, 8'hAB, 3);
    check_arch();
    check("jun_pc2ab", bus.rom_addr, 12'h2AB);
    check("jun_acc_kept", acc_out, 4'h1);

    // INC R15 wraps with carry untouched; then XCH with acc=7
    run(8'hDF, 8'h00); run(8'hBF, 8'h00); run(8'hFA, 8'h00);
    run(8'h6F, 8'h00);
    reg_rd_addr = 4'hF; #1;
    check("inc_r15", reg_rd_data, 4'h0);
    check("inc_cy", cy_out, 1'b1);
    run(8'hD7, 8'h00); run(8'hBF, 8'h00);
    reg_rd_addr = 4'hF; #1;
    check("xch_acc", acc_out, 4'h0);
    check("xch_r15", reg_rd_data, 4'h7);

    // Illegal opcode, then pc wrap at 0xFFF including a JUN straddling the wrap
    run(8'h3C, 8'h00);
    run(8'h4F, 8'hFF);
    run(8'h00, 8'h00);
    check("wrap_pc", bus.rom_addr, 12'h000);
    run(8'h4F, 8'hFF);
    run(8'h41, 8'h23);
    check("wrap_jun", bus.rom_addr, 12'h123);

    // Random programs with random ack latency
    for (int i = 0; i < 300; i++) begin
      b1 = 8'($urandom); b2 = 8'($urandom);
      exec_instr(b1, b2, $urandom_range(0, 2));
      check_arch();
    end
    for (int i = 0; i < 16; i++) begin
      reg_rd_addr = 4'(i); #1;
      check("final_reg", reg_rd_data, m_r[i]);
    end

    // Reset in FETCH2 with a coincident ack
    step_ack(8'h47, 0, 2'd0);
    m_pc = m_pc + 12'd1;
    @(negedge clk);
    check("f2_state", state, 2'd1);
    bus.rom_ack = 1'b1; bus.rom_data = 8'h55; rst = 1'b1;
    @(negedge clk);
    model_reset();
    check("rstf2_req", bus.rom_req, 1'b0);
    check("rstf2_pc", bus.rom_addr, 12'h000);
    check("rstf2_state", state, 2'd0);
    bus.rom_ack = 1'b0; rst = 1'b0;
    #1 check("rstf2_rel_req", bus.rom_req, 1'b1);
    run(8'hD3, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
